// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder; the single arithmetic cell the controller
// time-shares across all operand bits.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain full-adder equations.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller. One full-adder cell processes the
// operands LSB first, one bit per clock, with the carry fed back through a
// flop. A start accepted in IDLE or DONE yields a one-cycle done pulse
// WIDTH+1 cycles later with {cout,sum} = a+b+cin.
// Optional build macro SERIAL_ADD_SUB_EN adds a sub input: sub=1 computes
// a-b (b inverted, carry-in forced to 1), cout=1 meaning no borrow.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr;
  // Partial-sum register only keeps the upper WIDTH-1 bits; the bit that
  // would fall off the bottom is consumed directly into sum on the last step.
  logic [WIDTH-1:1] s_sr;
  logic [WIDTH-1:0] s_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cell_s, cell_c;
  logic             accept, last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  serial_fa_cell u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .sum (cell_s),
    .cout(cell_c)
  );

  // Operand conditioning at load time: subtraction is a + ~b + 1.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
`else
    b_load = b;
    c_load = cin;
`endif
  end

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last   = (state == ST_RUN) && (cnt == LAST);
  assign s_nxt  = {cell_s, s_sr};
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start only matters outside RUN; RUN ends on the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, capture on last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= s_nxt[WIDTH-1:1];
      carry <= cell_c;
      // Wrap to zero on the last bit so the counter never holds WIDTH.
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) begin
        sum  <= s_nxt;
        cout <= cell_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: reset/abort, a vector table (fixed + random)
// on an 8-bit instance, back-to-back and ignored-start sequences, and an
// exhaustive sweep on a 3-bit instance.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, cin, busy, done, cout;
  logic [7:0] a, b, sum;
  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub, sub3;
`endif

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub3),
`endif
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [8:0] prev;  // {cout,sum} the DUT should be holding

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the whole operands.
  function automatic logic [8:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input logic c, input logic s);
    logic [7:0] d;
    if (s) begin
      d = x - y;
      return {(x >= y), d};
    end
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  // Drive a request just after a negedge; returns at the negedge after acceptance.
  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
    a = x; b = y; cin = c;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`else
    if (s) $display("note: sub request ignored in add-only build");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // k counts negedges after the accepting edge; done is due at k == 9.
  task automatic wait_done(input string nm, input logic [8:0] exp, input int k0);
    int k = k0;
    bit ok = 0, busy_ok = 1, hold_ok = 1;
    while (k <= 20) begin
      if (done) begin ok = 1; break; end
      if (!busy) busy_ok = 0;
      if ({cout, sum} !== prev) hold_ok = 0;
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, ok ? k : 0, 9);
    chk({nm, " busy_in_run"}, busy_ok, 1);
    chk({nm, " result_held"}, hold_ok, 1);
    chk({nm, " busy_at_done"}, busy, 0);
    chk({nm, " result"}, {cout, sum}, exp);
    prev = exp;
  endtask

  initial begin
    int ndone;
    logic [3:0] res3;

    // Reset with start held high.
    rst_n = 1'b0; start = 1'b1; a = 8'h3C; b = 8'h0F; cin = 1'b1;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0; sub3 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 8'h00);
    chk("reset cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first accept busy", busy, 1);
    start = 1'b0;

    // Abort with reset at cnt=4: no done, result stays at reset value.
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no_done", ndone, 0);
    chk("abort result", {cout, sum}, 9'h000);
    prev = 9'h000;

    // Vector table: fixed cases then random ones from the model.
    tbl.push_back('{8'h3C, 8'h0F, 1'b1, 1'b0, 9'h04C});
    tbl.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100});
    tbl.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 9'h000});
    tbl.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF});
    tbl.push_back('{8'hAA, 8'h55, 1'b0, 1'b0, 9'h0FF});
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v.a = 8'($urandom); v.b = 8'($urandom); v.cin = 1'($urandom);
      v.sub = 1'b0;
      v.exp = ref_op(v.a, v.b, v.cin, 1'b0);
      tbl.push_back(v);
    end
    for (int i = 0; i < tbl.size(); i++) begin
      launch(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      wait_done($sformatf("vec%0d", i), tbl[i].exp, 1);
      @(negedge clk);
      chk($sformatf("vec%0d done_pulse", i), done, 0);
    end

    // Back-to-back: second start lands in the DONE cycle.
    launch(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done("b2b first", 9'h100, 1);
    launch(8'h80, 8'h80, 1'b1, 1'b0);
    wait_done("b2b second", 9'h101, 1);
    @(negedge clk);
    chk("b2b done_pulse", done, 0);

    // Start re-pulsed at cnt=3 with other operands is ignored.
    launch(8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore start", 9'h046, 5);
    @(negedge clk);
    chk("ignore done_pulse", done, 0);

`ifdef SERIAL_ADD_SUB_EN
    launch(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done("sub 10-01", 9'h10F, 1);
    @(negedge clk);
    launch(8'h01, 8'h02, 1'b1, 1'b1);
    wait_done("sub 01-02", 9'h0FF, 1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom); y = 8'($urandom);
      launch(x, y, 1'($urandom), 1'b1);
      wait_done($sformatf("sub rnd%0d", i), ref_op(x, y, 1'b0, 1'b1), 1);
      @(negedge clk);
    end
    sub = 1'b0;
`endif

    // Exhaustive 3-bit sweep: one done per start, {cout,sum} == a+b+cin.
    for (int i = 0; i < 128; i++) begin
      logic [6:0] iv;
      iv = 7'(i);
      a3 = iv[2:0]; b3 = iv[5:3]; cin3 = iv[6];
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      ndone = 0;
      res3 = 4'hx;
      for (int k = 1; k <= 6; k++) begin
        if (done3) begin ndone++; res3 = {cout3, sum3}; end
        @(negedge clk);
      end
      chk($sformatf("w3 %0d done_count", i), ndone, 1);
      chk($sformatf("w3 %0d result", i), res3, 4'(a3) + 4'(b3) + 4'(cin3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
